// File: rtl/branch_predictor_if.sv
// Fetch/execute-side bundle for the branch predictor.
// Master drives PC and resolutions; slave returns predictions and stats.
interface branch_predictor_if #(
    parameter int N     = 32,
    parameter int IDX_W = 6,
    parameter int CNT_W = 16
);
    logic [N-1:0]     pc;
    logic             pred_taken;
    logic [IDX_W-1:0] pred_idx;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             upd_pred;
    logic             mispredict;
    logic [CNT_W-1:0] miss_cnt;

    modport master (
        output pc, upd_valid, upd_idx, upd_taken, upd_pred,
        input  pred_taken, pred_idx, mispredict, miss_cnt
    );

    modport slave (
        input  pc, upd_valid, upd_idx, upd_taken, upd_pred,
        output pred_taken, pred_idx, mispredict, miss_cnt
    );
endinterface

// File: rtl/branch_predictor.sv
// 2-bit saturating-counter direction predictor with miss statistics.
// Define BP_GHR_EN to XOR a global history register into the index.
module branch_predictor #(
    parameter int N     = 32,
    parameter int IDX_W = 6,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst_n,
    branch_predictor_if.slave bp
);
    localparam int DEPTH = 2 ** IDX_W;

    logic [1:0]       tbl [DEPTH];
    logic [1:0]       cur;
    logic [1:0]       nxt;
    logic [IDX_W-1:0] pc_idx;
    logic             unused_pc;

    assign pc_idx    = bp.pc[IDX_W+1:2];
    assign unused_pc = ^{bp.pc[N-1:IDX_W+2], bp.pc[1:0]};

`ifdef BP_GHR_EN
    logic [IDX_W-1:0] ghr;

    // History advances at resolution time, so it is never speculative.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (bp.upd_valid) begin
            ghr <= {ghr[IDX_W-2:0], bp.upd_taken};
        end
    end

    assign bp.pred_idx = pc_idx ^ ghr;
`else
    assign bp.pred_idx = pc_idx;
`endif

    assign bp.pred_taken = tbl[bp.pred_idx][1];

    always_comb begin
        cur = tbl[bp.upd_idx];
        nxt = cur;
        if (bp.upd_taken && cur != 2'b11) begin
            nxt = cur + 2'd1;
        end else if (!bp.upd_taken && cur != 2'b00) begin
            nxt = cur - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= 2'b01;
            end
        end else if (bp.upd_valid) begin
            tbl[bp.upd_idx] <= nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp.mispredict <= 1'b0;
            bp.miss_cnt   <= '0;
        end else begin
            bp.mispredict <= bp.upd_valid &&
                             (bp.upd_taken != bp.upd_pred);
            if (bp.upd_valid && (bp.upd_taken != bp.upd_pred) &&
                !(&bp.miss_cnt)) begin
                bp.miss_cnt <= bp.miss_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor.
// Vector table for the main sequence, hand sequences for reset/hash.
module tb_branch_predictor;
    logic clk;
    logic rst_n;

    branch_predictor_if #(.N(32), .IDX_W(6), .CNT_W(16)) bp ();

    branch_predictor #(.N(32), .IDX_W(6), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        uv;
        logic [5:0]  ui;
        logic        ut;
        logic        up;
        logic [5:0]  e_idx;
        logic        e_tk;
        logic [1:0]  e_cnt;
    } vec_t;

    typedef struct {
        logic        mis;
        logic [15:0] cnt;
    } sb_t;

    vec_t        v [9];
    sb_t         q [$];
    sb_t         s;
    int          errors;
    int          checks;
    logic [15:0] miss_m;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic uv, input logic ut,
                            input logic up);
        sb_t e;
        e.mis = uv && (ut != up);
        if (e.mis && miss_m != 16'hffff) miss_m++;
        e.cnt = miss_m;
        q.push_back(e);
    endtask

    task automatic drive(input logic [31:0] pc, input logic uv,
                         input logic [5:0] ui, input logic ut,
                         input logic up);
        bp.pc        = pc;
        bp.upd_valid = uv;
        bp.upd_idx   = ui;
        bp.upd_taken = ut;
        bp.upd_pred  = up;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        miss_m = '0;
        rst_n  = 1'b0;
        drive(32'h40, 1'b0, 6'h0, 1'b0, 1'b0);

        //        pc     uv  ui   ut  up  idx  tk  cnt
        v[0] = '{32'h40, 1, 6'h10, 1, 0, 6'h10, 0, 2'b10};
        v[1] = '{32'h40, 1, 6'h10, 1, 1, 6'h10, 1, 2'b11};
        v[2] = '{32'h40, 1, 6'h10, 1, 1, 6'h10, 1, 2'b11};
        v[3] = '{32'h40, 1, 6'h10, 1, 1, 6'h10, 1, 2'b11};
        v[4] = '{32'h40, 1, 6'h10, 1, 1, 6'h10, 1, 2'b11};
        v[5] = '{32'h40, 1, 6'h10, 0, 1, 6'h10, 1, 2'b10};
        v[6] = '{32'h40, 0, 6'h10, 0, 1, 6'h10, 1, 2'b10};
        v[7] = '{32'h44, 1, 6'h11, 0, 0, 6'h11, 0, 2'b00};
        v[8] = '{32'h44, 1, 6'h11, 1, 0, 6'h11, 0, 2'b01};

        #1;
        chk("rst_idx", 32'(bp.pred_idx), 32'h10);
        chk("rst_taken", 32'(bp.pred_taken), 0);
        chk("rst_mispredict", 32'(bp.mispredict), 0);
        chk("rst_miss_cnt", 32'(bp.miss_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

`ifndef BP_GHR_EN
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(v[i].pc, v[i].uv, v[i].ui, v[i].ut, v[i].up);
            #1;
            chk($sformatf("v%0d_idx", i), 32'(bp.pred_idx),
                32'(v[i].e_idx));
            chk($sformatf("v%0d_taken", i), 32'(bp.pred_taken),
                32'(v[i].e_tk));
            push_exp(v[i].uv, v[i].ut, v[i].up);
            @(posedge clk);
            #1;
            s = q.pop_front();
            chk($sformatf("v%0d_mispredict", i), 32'(bp.mispredict),
                32'(s.mis));
            chk($sformatf("v%0d_miss_cnt", i), 32'(bp.miss_cnt),
                32'(s.cnt));
            chk($sformatf("v%0d_counter", i), 32'(dut.tbl[v[i].ui]),
                32'(v[i].e_cnt));
        end

        // Trained state: 0x10 at 10, mispredict high, miss_cnt 3.
        drive(32'h40, 1'b0, 6'h0, 1'b0, 1'b0);
        #1;
        chk("pre_rst_taken", 32'(bp.pred_taken), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_taken", 32'(bp.pred_taken), 0);
        chk("async_rst_mispredict", 32'(bp.mispredict), 0);
        chk("async_rst_miss_cnt", 32'(bp.miss_cnt), 0);
        chk("async_rst_counter", 32'(dut.tbl[6'h10]), 32'h1);
        @(negedge clk);
        rst_n  = 1'b1;
        miss_m = '0;
`endif

        // Lookup and update of the same entry in one cycle.
        @(negedge clk);
        drive(32'h40, 1'b1, 6'h10, 1'b0, 1'b0);
        #1;
        chk("same_cycle_taken", 32'(bp.pred_taken), 0);
        @(posedge clk);
        #1;
        drive(32'h44, 1'b0, 6'h0, 1'b0, 1'b0);
        #1;
        chk("same_cycle_counter", 32'(dut.tbl[6'h10]), 32'h0);
        chk("same_cycle_mispredict", 32'(bp.mispredict), 0);
        chk("other_idx_taken", 32'(bp.pred_taken), 0);
        chk("other_idx_counter", 32'(dut.tbl[6'h11]), 32'h1);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        drive(32'h40, 1'b1, 6'h20, 1'b1, 1'b1);
        @(negedge clk);
        drive(32'h40, 1'b1, 6'h20, 1'b1, 1'b1);
        @(negedge clk);
        drive(32'h40, 1'b0, 6'h0, 1'b0, 1'b0);
        #1;
`ifdef BP_GHR_EN
        chk("ghr_idx", 32'(bp.pred_idx), 32'h13);
`else
        chk("nohist_idx", 32'(bp.pred_idx), 32'h10);
`endif
        chk("hist_upd_counter", 32'(dut.tbl[6'h20]), 32'h3);
        chk("hist_miss_cnt", 32'(bp.miss_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
